// File: rtl/element_delay_accumulator.sv
// Sweep sequencer for the next-element increment calculator: runs one calculator
// step per array step, accumulates +n/-n distances with clamping, streams them out.
module element_delay_accumulator #(
  parameter int DW_INTEGER  = 18,
  parameter int DW_FRACTION = 6,
  parameter int DW_INPUT    = 8,
  parameter int ANGLE_DW    = 8,
  parameter int NUM_STEPS   = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [DW_INPUT-1:0]                  r_0,
  input  logic [ANGLE_DW-1:0]                  angle,
  output logic [DW_INPUT-1:0]                  calc_r_0,
  output logic [ANGLE_DW-1:0]                  calc_angle,
  output logic                                 calc_initiate,
  output logic                                 calc_ack,
  input  logic                                 calc_ready,
  input  logic [DW_INTEGER+DW_FRACTION:0]      calc_term_pos,
  input  logic [DW_INTEGER+DW_FRACTION:0]      calc_term_neg,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(NUM_STEPS+1)-1:0]       out_index,
  output logic [DW_INTEGER+DW_FRACTION:0]      out_dist_pos,
  output logic [DW_INTEGER+DW_FRACTION:0]      out_dist_neg,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 sat
);

  localparam int W  = DW_INTEGER + DW_FRACTION + 1;
  localparam int IW = $clog2(NUM_STEPS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STEPS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EMIT = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_ACK  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [W-1:0]      pos_acc_r, neg_acc_r;
  logic [IW-1:0]     index_r;
  logic              sat_r;
  logic [DW_INPUT-1:0] r_0_r;
  logic [ANGLE_DW-1:0] angle_r;
  logic              out_valid_r, calc_initiate_r, calc_ack_r, busy_r, done_r;
  logic [W:0]        pos_sum_s, neg_sum_s;
  logic [W-1:0]      init_acc_s;

  // Accumulators never go negative, so a set sign bit of the W+1 sum means underflow
  // and a set bit W-1 (with clear sign) means the positive range was exceeded.
  function automatic logic [W-1:0] clamp_sum(input logic [W:0] sum);
    if (sum[W]) begin
      clamp_sum = {W{1'b0}};
    end else if (sum[W-1]) begin
      clamp_sum = {1'b0, {(W-1){1'b1}}};
    end else begin
      clamp_sum = sum[W-1:0];
    end
  endfunction

  function automatic logic clamp_hit(input logic [W:0] sum);
    clamp_hit = sum[W] | sum[W-1];
  endfunction

  assign init_acc_s = {{(W-DW_INPUT-DW_FRACTION){1'b0}}, r_0, {DW_FRACTION{1'b0}}};
  assign pos_sum_s  = {pos_acc_r[W-1], pos_acc_r} + {calc_term_pos[W-1], calc_term_pos};
  assign neg_sum_s  = {neg_acc_r[W-1], neg_acc_r} + {calc_term_neg[W-1], calc_term_neg};

  // Next-state decode of the sweep sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: if (start) state_s = S_EMIT; else state_s = S_IDLE;
      S_EMIT: begin
        if (out_ready) begin
          if (index_r == LAST_IDX) state_s = S_DONE;
          else                     state_s = S_REQ;
        end else begin
          state_s = S_EMIT;
        end
      end
      S_REQ:  state_s = S_WAIT;
      S_WAIT: if (calc_ready) state_s = S_ACK; else state_s = S_WAIT;
      S_ACK:  state_s = S_EMIT;
      S_DONE: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, registered strobes (decoded from next state) and the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      out_valid_r     <= 1'b0;
      calc_initiate_r <= 1'b0;
      calc_ack_r      <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      sat_r           <= 1'b0;
      index_r         <= {IW{1'b0}};
      pos_acc_r       <= {W{1'b0}};
      neg_acc_r       <= {W{1'b0}};
      r_0_r           <= {DW_INPUT{1'b0}};
      angle_r         <= {ANGLE_DW{1'b0}};
    end else begin
      state_r         <= state_s;
      out_valid_r     <= (state_s == S_EMIT);
      calc_initiate_r <= (state_s == S_REQ);
      calc_ack_r      <= (state_s == S_ACK);
      busy_r          <= (state_s != S_IDLE);
      done_r          <= (state_s == S_DONE);
      if ((state_r == S_IDLE) && start) begin
        r_0_r     <= r_0;
        angle_r   <= angle;
        pos_acc_r <= init_acc_s;
        neg_acc_r <= init_acc_s;
        index_r   <= {IW{1'b0}};
        sat_r     <= 1'b0;
      end else if ((state_r == S_WAIT) && calc_ready) begin
        pos_acc_r <= clamp_sum(pos_sum_s);
        neg_acc_r <= clamp_sum(neg_sum_s);
        index_r   <= index_r + IW'(1'b1);
        sat_r     <= sat_r | clamp_hit(pos_sum_s) | clamp_hit(neg_sum_s);
      end
    end
  end

  assign calc_r_0      = r_0_r;
  assign calc_angle    = angle_r;
  assign calc_initiate = calc_initiate_r;
  assign calc_ack      = calc_ack_r;
  assign out_valid     = out_valid_r;
  assign out_index     = index_r;
  assign out_dist_pos  = pos_acc_r;
  assign out_dist_neg  = neg_acc_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign sat           = sat_r;

endmodule

// File: tb/tb_element_delay_accumulator.sv
// Directed bench for element_delay_accumulator with a behavioural calculator
// responder (selectable terms and latency) and a clamped-accumulation reference.
module tb_element_delay_accumulator;

  localparam int MAXD = 16777215;

  logic        clk, rst, start;
  logic [7:0]  r_0, angle, calc_r_0, calc_angle;
  logic        calc_initiate, calc_ack, calc_ready;
  logic [24:0] calc_term_pos, calc_term_neg, out_dist_pos, out_dist_neg;
  logic        out_valid, out_ready, busy, done, sat;
  logic [5:0]  out_index;

  int n_checks = 0;
  int n_errors = 0;
  int term_mode = 0;   // 0: +-32, 1: varying, 2: saturating
  int lat_mode = 0;    // 0: latency 1, 1: 0/1/7 cycling, 2: never respond
  int run_idx = 0;
  int init_cnt = 0, ack_cnt = 0, done_cnt = 0;
  int beat_pos [0:32];
  int beat_neg [0:32];

  element_delay_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .r_0(r_0), .angle(angle),
    .calc_r_0(calc_r_0), .calc_angle(calc_angle),
    .calc_initiate(calc_initiate), .calc_ack(calc_ack), .calc_ready(calc_ready),
    .calc_term_pos(calc_term_pos), .calc_term_neg(calc_term_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_dist_pos(out_dist_pos), .out_dist_neg(out_dist_neg),
    .busy(busy), .done(done), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int term_val(input int mode, input int step, input bit neg);
    case (mode)
      0:       return neg ? -32 : 32;
      1:       return neg ? (12 - 2 * step) : (40 + 7 * step);
      default: return neg ? -20000 : MAXD;
    endcase
  endfunction

  function automatic int lat_val(input int mode, input int step);
    case (mode)
      0:       return 1;
      1:       return (step % 3 == 0) ? 0 : ((step % 3 == 1) ? 1 : 7);
      default: return 1000;
    endcase
  endfunction

  // handshake counters
  initial begin
    forever begin
      @(negedge clk);
      if (calc_initiate) init_cnt++;
      if (calc_ack) ack_cnt++;
      if (done) done_cnt++;
    end
  end

  // calculator responder: ready held through ACK and one more cycle
  initial begin
    calc_ready = 1'b0;
    calc_term_pos = 25'd0;
    calc_term_neg = 25'd0;
    forever begin
      @(negedge clk);
      if (calc_initiate && !rst) begin
        int step, lat;
        bit abort;
        step = run_idx;
        run_idx++;
        lat = lat_val(lat_mode, step);
        abort = 1'b0;
        @(negedge clk);
        if (rst) abort = 1'b1;
        for (int i = 0; i < lat && !abort; i++) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
        if (!abort) begin
          calc_term_pos = 25'(term_val(term_mode, step, 1'b0));
          calc_term_neg = 25'(term_val(term_mode, step, 1'b1));
          calc_ready = 1'b1;
          @(negedge clk);
          check_value("ack_after_ready", calc_ack, 1);
          @(negedge clk);
          calc_ready = 1'b0;
          calc_term_pos = 25'd999;
          calc_term_neg = 25'd999;
        end
      end
    end
  end

  task automatic wait_valid(output bit ok);
    int waited = 0;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    ok = out_valid;
    if (!ok) check_value("beat_timeout", 0, 1);
  endtask

  task automatic run_sweep(input int r0, input int ang, input int bp_beat);
    int exp_pos, exp_neg, s;
    bit exp_sat, ok;
    logic [24:0] hold_pos, hold_neg;
    logic [5:0] hold_idx;
    run_idx = 0; init_cnt = 0; ack_cnt = 0; done_cnt = 0;
    r_0 = 8'(r0); angle = 8'(ang); out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_value("busy_after_start", busy, 1);
    check_value("calc_r_0", calc_r_0, 64'(r0));
    check_value("calc_angle", calc_angle, 64'(ang));
    exp_pos = r0 * 64; exp_neg = r0 * 64; exp_sat = 1'b0;
    for (int idx = 0; idx <= 32; idx++) begin
      wait_valid(ok);
      if (!ok) return;
      check_value("out_index", out_index, 64'(idx));
      check_value("dist_pos", out_dist_pos, 64'(exp_pos));
      check_value("dist_neg", out_dist_neg, 64'(exp_neg));
      check_value("sat", sat, 64'(exp_sat));
      beat_pos[idx] = int'(out_dist_pos);
      beat_neg[idx] = int'(out_dist_neg);
      if (idx == bp_beat) begin
        out_ready = 1'b0;
        hold_pos = out_dist_pos; hold_neg = out_dist_neg; hold_idx = out_index;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check_value("bp_stable", {out_valid, out_index, out_dist_pos, out_dist_neg, calc_initiate},
                      {1'b1, hold_idx, hold_pos, hold_neg, 1'b0});
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (idx < 32) begin
        check_value("initiate_after_beat", calc_initiate, 1);
        s = exp_pos + term_val(term_mode, idx, 1'b0);
        if (s > MAXD) begin s = MAXD; exp_sat = 1'b1; end
        else if (s < 0) begin s = 0; exp_sat = 1'b1; end
        exp_pos = s;
        s = exp_neg + term_val(term_mode, idx, 1'b1);
        if (s > MAXD) begin s = MAXD; exp_sat = 1'b1; end
        else if (s < 0) begin s = 0; exp_sat = 1'b1; end
        exp_neg = s;
      end else begin
        check_value("done_pulse", {done, busy, out_valid}, 3'b110);
        @(negedge clk);
        check_value("idle_after_done", {done, busy}, 2'b00);
      end
    end
    check_value("initiate_count", init_cnt, 32);
    check_value("ack_count", ack_cnt, 32);
    check_value("done_count", done_cnt, 1);
  endtask

  task automatic reset_mid_wait();
    bit ok;
    run_idx = 0; done_cnt = 0;
    r_0 = 8'd10; angle = 8'd60; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int idx = 0; idx <= 5; idx++) begin
      wait_valid(ok);
      if (!ok) return;
      if (idx == 5) lat_mode = 2;
      @(negedge clk);
    end
    @(negedge clk);
    r_0 = 8'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_value("busy_start_ignored", {busy, out_valid, calc_initiate, calc_r_0}, {3'b100, 8'd10});
    rst = 1'b1;
    @(negedge clk);
    check_value("rst_flags", {busy, done, sat, out_valid, calc_initiate, calc_ack, out_index}, 64'd0);
    check_value("rst_data", {out_dist_pos, out_dist_neg, calc_r_0}, 64'd0);
    @(negedge clk);
    rst = 1'b0; lat_mode = 0;
    check_value("no_done_on_reset", done_cnt, 0);
    run_sweep(10, 60, -1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; r_0 = 8'd0; angle = 8'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset_flags", {busy, done, sat, out_valid, calc_initiate, calc_ack, out_index}, 64'd0);
    check_value("reset_data", {out_dist_pos, out_dist_neg, calc_r_0, calc_angle}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    term_mode = 0; lat_mode = 0;
    run_sweep(10, 60, -1);
    check_value("basic_b0_pos", beat_pos[0], 640);
    check_value("basic_b0_neg", beat_neg[0], 640);
    check_value("basic_b1_pos", beat_pos[1], 672);
    check_value("basic_b1_neg", beat_neg[1], 608);
    check_value("basic_b32_pos", beat_pos[32], 1664);
    check_value("basic_b32_neg", beat_neg[32], 0);
    check_value("basic_final_sat", sat, 1);

    term_mode = 2;
    run_sweep(255, 60, -1);
    check_value("sat_b0_pos", beat_pos[0], 16320);
    check_value("sat_b1_pos", beat_pos[1], MAXD);
    check_value("sat_b1_neg", beat_neg[1], 0);
    check_value("sat_final", sat, 1);

    term_mode = 1;
    run_sweep(10, 60, 3);

    lat_mode = 1;
    run_sweep(10, 60, -1);

    term_mode = 0; lat_mode = 0;
    reset_mid_wait();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/element_delay_accumulator.md
# element_delay_accumulator

Downstream consumer and sequencer for `NextElementIncrementTermCalculator`. It launches one calculator run per array step using the initiate/ack handshake. It accumulates the returned positive-side and negative-side increment terms onto the focal distance `r_0`, and streams the per-element distances for elements ±n to the delay-to-sample stage over a valid/ready interface. One `start` pulse produces `NUM_STEPS+1` output beats.

## Interface
Parameters:
- `DW_INTEGER`, 18, integer bits of distance/term fixed-point.
- `DW_FRACTION`, 6, fraction bits.
- `DW_INPUT`, 8, width of `r_0`.
- `ANGLE_DW`, 8, width of `angle`.
- `NUM_STEPS`, 32, calculator runs per sweep.

Derived: W = DW_INTEGER+DW_FRACTION+1 (signed two's complement), IW = clog2(NUM_STEPS+1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: sweep request pulse, sampled only in IDLE.
- `r_0` in DW_INPUT: focal distance, integer, latched on accepted `start`.
- `angle` in ANGLE_DW: steering angle, latched on accepted `start`.
- `calc_r_0` out DW_INPUT: latched `r_0`, held stable for the calculator.
- `calc_angle` out ANGLE_DW: latched `angle`.
- `calc_initiate` out 1: one-cycle run request.
- `calc_ack` out 1: one-cycle result acknowledge.
- `calc_ready` in 1: calculator result valid.
- `calc_term_pos` in W: signed increment term for element +n.
- `calc_term_neg` in W: signed increment term for element −n.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accept.
- `out_index` out IW: element magnitude n.
- `out_dist_pos` out W: distance for element +n.
- `out_dist_neg` out W: distance for element −n.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `sat` out 1: sticky saturation flag, cleared on accepted `start`.

## Operation
- States: IDLE, EMIT, REQ, WAIT, ACK, DONE.
- IDLE, on `start`=1:
  - Latch `r_0` and `angle`.
  - Set pos_acc = neg_acc = `r_0` << DW_FRACTION (zero-extended to W).
  - Set index = 0, clear `sat`.
  - Go to EMIT.
- EMIT:
  - `out_valid`=1, driving index and both accumulators.
  - On `out_ready`=1: go to DONE if index==NUM_STEPS, otherwise go to REQ.
- REQ: `calc_initiate`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `calc_ready`=1:
  - Capture both terms and update pos_acc += `calc_term_pos`, neg_acc += `calc_term_neg`.
  - index += 1, then go to ACK.
- ACK: `calc_ack`=1 for exactly this cycle, then go to EMIT.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Arithmetic:
  - Each sum is computed at W+1 bits.
  - Result > 2^(W−1)−1 clamps to 2^(W−1)−1. Result < 0 clamps to 0.
  - Either clamp sets `sat`; `sat` holds until the next accepted `start`.
- Boundaries:
  - `start` is ignored while `busy`=1.
  - `calc_ready` is ignored outside WAIT.
  - `out_ready` is ignored outside EMIT.
  - While `out_valid`=1 and `out_ready`=0, all out_* signals hold stable indefinitely.
  - `calc_r_0`/`calc_angle` change only on an accepted `start`.

## Timing
- Reset values:
  - State = IDLE.
  - All 1-bit outputs = 0.
  - `out_index`, `out_dist_*`, `calc_r_0`, `calc_angle` = 0.
  - `rst` asserted in any state forces these values on the next edge. No calculator handshake is completed, and no `done` is produced.
- `start` accepted at edge t: `busy`=1 and `out_valid`=1 for index 0 from t+1.
- Beat accepted at edge k (non-final):
  - `calc_initiate` high in cycle k+1.
  - WAIT from k+2.
- `calc_ready` seen at edge m:
  - `calc_ack` high in cycle m+1.
  - Next `out_valid` from m+2.
- Minimum step period with zero-latency downstream: 4 cycles plus calculator latency.
- Final beat accepted at edge f: `done`=1 in cycle f+1, IDLE (`busy`=0) in cycle f+2.
- `start` is accepted again from cycle f+2.

## Test plan
- Basic sweep: `r_0`=10, `angle`=60, model terms pos=+32, neg=−32, `out_ready`=1. Expect:
  - Beat 0: 640/640.
  - Beat 1: 672/608.
  - Beat 32: 1664/−384→0, with `sat`=1.
  - 33 beats, 32 initiate/ack pairs, single `done`.
- Real calculator (`r_0`=10, `angle`=60): every beat's distances equal a reference model accumulating the calculator outputs, and `out_index` counts 0..32.
- Backpressure: hold `out_ready`=0 for 5 cycles on beat 3. Expect out_* stable and no `calc_initiate` until acceptance.
- Saturation: `r_0`=255, pos term 16777215, neg term −20000. Expect `out_dist_pos`=16777215, `out_dist_neg`=0, `sat`=1. A new `start` clears `sat`.
- Variable latency: `calc_ready` delayed 0, 1, 7 cycles. Expect `calc_ack` exactly one cycle after each ready and no duplicate accumulation.
- Reset mid-WAIT after beat 5, plus `start` pulsed while busy: outputs return to reset values next edge. The busy `start` is ignored. A fresh `start` restarts at index 0 with 640/640.
